fall_ctrl_module: RTL and testbench

- Gravity and spawn sequencer for the active tetromino; sits directly upstream of the in-game process FSM.
- Gated by ingame_sig from that FSM, and produces the game_over level it consumes.
- Handshakes with the board collision checker (spawn/down tests) and the board merge/line-clear logic (lock).

---
 rtl/fall_ctrl_module_pkg.sv | 33 +++
 rtl/fall_ctrl_module_if.sv | 31 +++
 rtl/fall_ctrl_module_gravity.sv | 47 ++++
 rtl/fall_ctrl_module.sv | 126 ++++++++++++
 tb/tb_fall_ctrl_module.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fall_ctrl_module_pkg.sv
//----------------------------------------------------------------------------
// Module   : fall_ctrl_module_pkg
// Brief    : Shared state encoding and timing defaults for the fall controller.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package fall_ctrl_module_pkg;

    localparam int CLK_HZ      = 50000000;
    localparam int TICK_NORMAL = 25000000;
    localparam int TICK_FAST   = 2500000;
    localparam int CNT_W       = 25;

    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_SPAWN_ENC    = 3'd1;
    localparam logic [2:0] ST_FALL_ENC     = 3'd2;
    localparam logic [2:0] ST_DOWN_CHK_ENC = 3'd3;
    localparam logic [2:0] ST_LOCK_ENC     = 3'd4;
    localparam logic [2:0] ST_OVER_ENC     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_SPAWN    = ST_SPAWN_ENC,
        ST_FALL     = ST_FALL_ENC,
        ST_DOWN_CHK = ST_DOWN_CHK_ENC,
        ST_LOCK     = ST_LOCK_ENC,
        ST_OVER     = ST_OVER_ENC
    } state_e;

endpackage

`default_nettype wire

// File: rtl/fall_ctrl_module_if.sv
//----------------------------------------------------------------------------
// Module   : fall_ctrl_module_if
// Brief    : Game-state, checker and lock handshake bundle of the fall controller.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface fall_ctrl_module_if;
    logic ingame_sig;
    logic fast_drop;
    logic check_done;
    logic check_hit;
    logic lock_done;
    logic spawn_req;
    logic down_chk_req;
    logic move_down;
    logic lock_req;
    logic game_over;

    modport slave (
        input  ingame_sig, fast_drop, check_done, check_hit, lock_done,
        output spawn_req, down_chk_req, move_down, lock_req, game_over
    );

    modport master (
        output ingame_sig, fast_drop, check_done, check_hit, lock_done,
        input  spawn_req, down_chk_req, move_down, lock_req, game_over
    );
endinterface

`default_nettype wire

// File: rtl/fall_ctrl_module_gravity.sv
//----------------------------------------------------------------------------
// Module   : gravity_tick_module
// Brief    : Gravity step counter with normal/fast limit select.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module gravity_tick_module #(
    parameter int TICK_NORMAL = fall_ctrl_module_pkg::TICK_NORMAL,
    parameter int TICK_FAST   = fall_ctrl_module_pkg::TICK_FAST,
    parameter int CNT_W       = fall_ctrl_module_pkg::CNT_W
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic fast,
    output logic      tick
);

    localparam logic [CNT_W-1:0] c_last_normal = CNT_W'(TICK_NORMAL - 1);
    localparam logic [CNT_W-1:0] c_last_fast   = CNT_W'(TICK_FAST - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] limit;

    // >= rather than == so switching to fast mid-count fires immediately
    always_comb begin
        limit   = fast ? c_last_fast : c_last_normal;
        tick    = !clr && (count_q >= limit);
        count_d = count_q + 1'b1;
        if (clr || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fall_ctrl_module.sv
//----------------------------------------------------------------------------
// Module   : fall_ctrl_module
// Brief    : Gravity/spawn sequencer for the active tetromino.
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fall_ctrl_module #(
    parameter int TICK_NORMAL = fall_ctrl_module_pkg::TICK_NORMAL,
    parameter int TICK_FAST   = fall_ctrl_module_pkg::TICK_FAST,
    parameter int CNT_W       = fall_ctrl_module_pkg::CNT_W
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fall_ctrl_module_if.slave  bus
);

    import fall_ctrl_module_pkg::*;

    state_e state_q, state_d;
    logic   spawn_req_q, spawn_req_d;
    logic   down_chk_req_q, down_chk_req_d;
    logic   move_down_q, move_down_d;
    logic   lock_req_q, lock_req_d;
    logic   game_over_q, game_over_d;
    logic   tick;

    // Counter is held at zero outside FALL, so every FALL entry starts a fresh step
    gravity_tick_module #(
        .TICK_NORMAL (TICK_NORMAL),
        .TICK_FAST   (TICK_FAST),
        .CNT_W       (CNT_W)
    ) u_gravity (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != ST_FALL),
        .fast  (bus.fast_drop),
        .tick  (tick)
    );

    always_comb begin
        state_d        = state_q;
        spawn_req_d    = 1'b0;
        down_chk_req_d = 1'b0;
        move_down_d    = 1'b0;
        lock_req_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ingame_sig) begin
                    state_d     = ST_SPAWN;
                    spawn_req_d = 1'b1;
                end
            end
            ST_SPAWN: begin
                if (!bus.ingame_sig) begin
                    state_d = ST_IDLE;
                end else if (bus.check_done) begin
                    state_d = bus.check_hit ? ST_OVER : ST_FALL;
                end
            end
            ST_FALL: begin
                if (!bus.ingame_sig) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    state_d        = ST_DOWN_CHK;
                    down_chk_req_d = 1'b1;
                end
            end
            ST_DOWN_CHK: begin
                if (!bus.ingame_sig) begin
                    state_d = ST_IDLE;
                end else if (bus.check_done) begin
                    if (bus.check_hit) begin
                        state_d    = ST_LOCK;
                        lock_req_d = 1'b1;
                    end else begin
                        state_d     = ST_FALL;
                        move_down_d = 1'b1;
                    end
                end
            end
            ST_LOCK: begin
                if (!bus.ingame_sig) begin
                    state_d = ST_IDLE;
                end else if (bus.lock_done) begin
                    state_d     = ST_SPAWN;
                    spawn_req_d = 1'b1;
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            spawn_req_q    <= 1'b0;
            down_chk_req_q <= 1'b0;
            move_down_q    <= 1'b0;
            lock_req_q     <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            spawn_req_q    <= spawn_req_d;
            down_chk_req_q <= down_chk_req_d;
            move_down_q    <= move_down_d;
            lock_req_q     <= lock_req_d;
            game_over_q    <= game_over_d;
        end
    end

    assign bus.spawn_req    = spawn_req_q;
    assign bus.down_chk_req = down_chk_req_q;
    assign bus.move_down    = move_down_q;
    assign bus.lock_req     = lock_req_q;
    assign bus.game_over    = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_fall_ctrl_module.sv
//----------------------------------------------------------------------------
// Module   : tb_fall_ctrl_module
// Brief    : Directed self-checking bench for fall_ctrl_module (TICK 8/2).
// Revision : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_fall_ctrl_module;

    localparam logic [4:0] V_NONE  = 5'b00000;
    localparam logic [4:0] V_SPAWN = 5'b10000;
    localparam logic [4:0] V_DOWN  = 5'b01000;
    localparam logic [4:0] V_MOVE  = 5'b00100;
    localparam logic [4:0] V_LOCK  = 5'b00010;
    localparam logic [4:0] V_OVER  = 5'b00001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    fall_ctrl_module_if bus ();

    fall_ctrl_module #(
        .TICK_NORMAL (8),
        .TICK_FAST   (2),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [4:0] outs;
    assign outs = {bus.spawn_req, bus.down_chk_req, bus.move_down, bus.lock_req, bus.game_over};

    // Step negedges until any output is non-zero; n counts negedges waited
    task automatic wait_out(output int n, output logic [4:0] v);
        n = 0;
        v = V_NONE;
        while (n < 40) begin
            @(negedge clk);
            n++;
            v = outs;
            if (v != V_NONE) break;
        end
    endtask

    task automatic pulse_check(input logic hit);
        bus.check_done = 1'b1;
        bus.check_hit  = hit;
        @(negedge clk);
        bus.check_done = 1'b0;
        bus.check_hit  = 1'b0;
    endtask

    task automatic test_reset();
        bus.ingame_sig = 1'b0; bus.fast_drop = 1'b0;
        bus.check_done = 1'b0; bus.check_hit = 1'b0; bus.lock_done = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (outs !== V_NONE) begin n_bad++; $display("FAIL reset_outs: got %b want %b", outs, V_NONE); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (outs !== V_NONE) begin n_bad++; $display("FAIL idle_quiet: got %b want %b", outs, V_NONE); end
    endtask

    task automatic test_spawn_fall();
        int n; logic [4:0] v;
        bus.ingame_sig = 1'b1;
        wait_out(n, v);
        n_cmp++; if (n !== 1 || v !== V_SPAWN) begin n_bad++; $display("FAIL first_spawn: got n=%0d v=%b want n=1 v=%b", n, v, V_SPAWN); end
        @(negedge clk);
        n_cmp++; if (outs !== V_NONE) begin n_bad++; $display("FAIL spawn_width: got %b want %b", outs, V_NONE); end
        pulse_check(1'b0);
        wait_out(n, v);
        n_cmp++; if (n !== 8 || v !== V_DOWN) begin n_bad++; $display("FAIL first_down: got n=%0d v=%b want n=8 v=%b", n, v, V_DOWN); end
        pulse_check(1'b0);
        n_cmp++; if (outs !== V_MOVE) begin n_bad++; $display("FAIL move_down: got %b want %b", outs, V_MOVE); end
        wait_out(n, v);
        n_cmp++; if (n !== 8 || v !== V_DOWN) begin n_bad++; $display("FAIL second_down: got n=%0d v=%b want n=8 v=%b", n, v, V_DOWN); end
    endtask

    task automatic test_fast_drop();
        int n; logic [4:0] v;
        pulse_check(1'b0);
        n_cmp++; if (outs !== V_MOVE) begin n_bad++; $display("FAIL fast_move0: got %b want %b", outs, V_MOVE); end
        bus.fast_drop = 1'b1;
        wait_out(n, v);
        n_cmp++; if (n !== 2 || v !== V_DOWN) begin n_bad++; $display("FAIL fast_down1: got n=%0d v=%b want n=2 v=%b", n, v, V_DOWN); end
        pulse_check(1'b0);
        wait_out(n, v);
        n_cmp++; if (n !== 2 || v !== V_DOWN) begin n_bad++; $display("FAIL fast_down2: got n=%0d v=%b want n=2 v=%b", n, v, V_DOWN); end
        bus.fast_drop = 1'b0;
        pulse_check(1'b0);
        n_cmp++; if (outs !== V_MOVE) begin n_bad++; $display("FAIL fast_move3: got %b want %b", outs, V_MOVE); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_cmp++; if (outs !== V_NONE) begin n_bad++; $display("FAIL midcount_quiet%0d: got %b want %b", k, outs, V_NONE); end
        end
        bus.fast_drop = 1'b1;
        wait_out(n, v);
        n_cmp++; if (n !== 1 || v !== V_DOWN) begin n_bad++; $display("FAIL fast_midcount: got n=%0d v=%b want n=1 v=%b", n, v, V_DOWN); end
        bus.fast_drop = 1'b0;
    endtask

    task automatic test_lock();
        pulse_check(1'b1);
        n_cmp++; if (outs !== V_LOCK) begin n_bad++; $display("FAIL lock_req: got %b want %b", outs, V_LOCK); end
        repeat (2) begin
            @(negedge clk);
            n_cmp++; if (outs !== V_NONE) begin n_bad++; $display("FAIL lock_wait: got %b want %b", outs, V_NONE); end
        end
        bus.lock_done = 1'b1;
        @(negedge clk);
        bus.lock_done = 1'b0;
        n_cmp++; if (outs !== V_SPAWN) begin n_bad++; $display("FAIL respawn: got %b want %b", outs, V_SPAWN); end
        @(negedge clk);
        pulse_check(1'b0);
    endtask

    task automatic test_stray();
        int n; logic [4:0] v;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_cmp++; if (outs !== V_NONE) begin n_bad++; $display("FAIL stray_quiet%0d: got %b want %b", k, outs, V_NONE); end
            bus.check_done = (k == 2);
            bus.check_hit  = (k == 2);
            bus.lock_done  = (k == 4);
        end
        wait_out(n, v);
        n_cmp++; if (n !== 3 || v !== V_DOWN) begin n_bad++; $display("FAIL stray_down: got n=%0d v=%b want n=3 v=%b", n, v, V_DOWN); end
    endtask

    task automatic test_abort();
        int n; logic [4:0] v;
        bus.ingame_sig = 1'b0;
        pulse_check(1'b0);
        n_cmp++; if (outs !== V_NONE) begin n_bad++; $display("FAIL abort_no_move: got %b want %b", outs, V_NONE); end
        repeat (3) @(negedge clk);
        n_cmp++; if (outs !== V_NONE) begin n_bad++; $display("FAIL abort_idle: got %b want %b", outs, V_NONE); end
        bus.ingame_sig = 1'b1;
        wait_out(n, v);
        n_cmp++; if (n !== 1 || v !== V_SPAWN) begin n_bad++; $display("FAIL restart_spawn: got n=%0d v=%b want n=1 v=%b", n, v, V_SPAWN); end
    endtask

    task automatic test_game_over();
        @(negedge clk);
        pulse_check(1'b1);
        n_cmp++; if (outs !== V_OVER) begin n_bad++; $display("FAIL game_over_set: got %b want %b", outs, V_OVER); end
        for (int k = 0; k < 8; k++) begin
            bus.ingame_sig = k[0];
            bus.check_done = (k == 2);
            bus.lock_done  = (k == 4);
            @(negedge clk);
            n_cmp++; if (outs !== V_OVER) begin n_bad++; $display("FAIL over_sticky%0d: got %b want %b", k, outs, V_OVER); end
        end
        bus.ingame_sig = 1'b0; bus.check_done = 1'b0; bus.lock_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (outs !== V_NONE) begin n_bad++; $display("FAIL async_reset: got %b want %b", outs, V_NONE); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_spawn_fall();
        test_fast_drop();
        test_lock();
        test_stray();
        test_abort();
        test_game_over();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
